// File: rtl/noc_packet_injector.sv
// noc_packet_injector: turns a command plus a payload stream into header/body/tail NoC flits.
// Defining NOC_INJ_PKT_CNT_EN adds saturating packet and flit handshake counters.
module noc_packet_injector #(
  parameter int FLIT_WIDTH = 32,
  parameter int COORD_W = 2,
  parameter int SRC_X = 0,
  parameter int SRC_Y = 0
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [COORD_W-1:0]    cmd_dst_x,
  input  logic [COORD_W-1:0]    cmd_dst_y,
  input  logic [7:0]            cmd_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [FLIT_WIDTH-1:0] pl_data,
  output logic                  noc_valid,
  input  logic                  noc_ready,
  output logic [FLIT_WIDTH-1:0] noc_flit,
  output logic                  noc_is_header,
  output logic                  noc_is_tail
`ifdef NOC_INJ_PKT_CNT_EN
  ,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           flit_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
  localparam logic [COORD_W-1:0] SX = COORD_W'(SRC_X);
  localparam logic [COORD_W-1:0] SY = COORD_W'(SRC_Y);
  state_t state, state_n;
  logic [7:0] len, len_n, rem, rem_n;
  logic valid_n, hdr_n, tail_n, xfer, pl_xfer;
  logic [FLIT_WIDTH-1:0] flit_n, header;
  assign cmd_ready = state == IDLE;
  assign xfer = noc_valid && noc_ready;
  assign pl_ready = state == BODY && (!noc_valid || noc_ready) && rem != 8'd0;
  assign pl_xfer = pl_valid && pl_ready;
  always_comb begin
    header = '0;
    header[FLIT_WIDTH-1 -: 4*COORD_W] = {cmd_dst_x, cmd_dst_y, SX, SY};
    header[7:0] = cmd_len;
  end
  always_comb begin
    state_n = state;
    len_n = len;
    rem_n = rem;
    valid_n = noc_valid;
    flit_n = noc_flit;
    hdr_n = noc_is_header;
    tail_n = noc_is_tail;
    if (state == IDLE) begin
      if (cmd_valid) begin
        state_n = HEAD;
        len_n = cmd_len;
        valid_n = 1'b1;
        flit_n = header;
        hdr_n = 1'b1;
        tail_n = cmd_len == 8'd0;
      end
    end else if (state == HEAD) begin
      if (noc_ready) begin
        state_n = len == 8'd0 ? IDLE : BODY;
        rem_n = len;
        valid_n = 1'b0;
        hdr_n = 1'b0;
        tail_n = 1'b0;
      end
    end else if (pl_xfer) begin
      // a pending flit drains in the same cycle the next one loads
      valid_n = 1'b1;
      flit_n = pl_data;
      hdr_n = 1'b0;
      tail_n = rem == 8'd1;
      rem_n = rem - 8'd1;
    end else if (xfer) begin
      valid_n = 1'b0;
      tail_n = 1'b0;
      state_n = noc_is_tail ? IDLE : BODY;
    end
  end
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state <= IDLE;
      len <= '0;
      rem <= '0;
      noc_valid <= 1'b0;
      noc_flit <= '0;
      noc_is_header <= 1'b0;
      noc_is_tail <= 1'b0;
    end else begin
      state <= state_n;
      len <= len_n;
      rem <= rem_n;
      noc_valid <= valid_n;
      noc_flit <= flit_n;
      noc_is_header <= hdr_n;
      noc_is_tail <= tail_n;
    end
  end
`ifdef NOC_INJ_PKT_CNT_EN
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      pkt_cnt <= '0;
      flit_cnt <= '0;
    end else begin
      if (xfer && flit_cnt != 16'hFFFF) flit_cnt <= flit_cnt + 16'd1;
      if (xfer && noc_is_tail && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
`endif
endmodule
